// File: rtl/cplx_delay_line.sv
// rtl/cplx_delay_line.sv - complex re/im/valid delay line, circular buffer, D enabled cycles
// Optional macro CPLX_DLY_ZERO_FILL_EN zeroes o_re/o_im until primed.
module cplx_delay_line #(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         w_en,
    input  logic [W-1:0] i_re,
    input  logic [W-1:0] i_im,
    input  logic         i_vld,
    output logic [W-1:0] o_re,
    output logic [W-1:0] o_im,
    output logic         o_vld,
    output logic         primed
);

    localparam int AW  = (D > 1) ? $clog2(D) : 1;
    localparam int FCW = $clog2(D + 1);

    logic [W-1:0]   re_mem [D];
    logic [W-1:0]   im_mem [D];
    logic [D-1:0]   vld_q;
    logic [AW-1:0]  wp;
    logic [FCW-1:0] fc;
    logic           primed_q;
    logic           wr;
    logic [W-1:0]   rd_re;
    logic [W-1:0]   rd_im;

    assign wr = rst_n & w_en;

    // Data storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            re_mem[wp] <= i_re;
            im_mem[wp] <= i_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp       <= '0;
            fc       <= '0;
            vld_q    <= '0;
            primed_q <= 1'b0;
        end else if (w_en) begin
            vld_q[wp] <= i_vld;
            wp        <= (wp == AW'(D - 1)) ? '0 : wp + 1'b1;
            if (fc != FCW'(D))
                fc <= fc + 1'b1;
            if (fc == FCW'(D - 1))
                primed_q <= 1'b1;
        end
    end

    // Entry wp is the oldest sample; it is overwritten at the next enabled edge.
    assign rd_re = re_mem[wp];
    assign rd_im = im_mem[wp];

`ifdef CPLX_DLY_ZERO_FILL_EN
    assign o_re = primed_q ? rd_re : '0;
    assign o_im = primed_q ? rd_im : '0;
`else
    assign o_re = rd_re;
    assign o_im = rd_im;
`endif

    assign o_vld  = vld_q[wp] & primed_q;
    assign primed = primed_q;

endmodule

// File: tb/tb_cplx_delay_line.sv
// tb/tb_cplx_delay_line.sv - self-checking bench for cplx_delay_line at depths 1, 4, 7 and 8
module tb_cplx_delay_line;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_en;
    logic [15:0] i_re;
    logic [15:0] i_im;
    logic        i_vld;

    logic [15:0] re1, im1, re4, im4, re7, im7, re8, im8;
    logic        v1, p1, v4, p4, v7, p7, v8, p8;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        vld;
    } ent_t;

    // Every sample accepted since the last reset, oldest first.
    ent_t hist[$];

    always #5 clk = ~clk;

    cplx_delay_line #(.W(16), .D(1)) u1 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .i_re(i_re), .i_im(i_im),
        .i_vld(i_vld), .o_re(re1), .o_im(im1), .o_vld(v1), .primed(p1));
    cplx_delay_line #(.W(16), .D(4)) u4 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .i_re(i_re), .i_im(i_im),
        .i_vld(i_vld), .o_re(re4), .o_im(im4), .o_vld(v4), .primed(p4));
    cplx_delay_line #(.W(16), .D(7)) u7 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .i_re(i_re), .i_im(i_im),
        .i_vld(i_vld), .o_re(re7), .o_im(im7), .o_vld(v7), .primed(p7));
    cplx_delay_line #(.W(16), .D(8)) u8 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .i_re(i_re), .i_im(i_im),
        .i_vld(i_vld), .o_re(re8), .o_im(im8), .o_vld(v8), .primed(p8));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n)
            hist.delete();
        else if (w_en)
            hist.push_back('{re: i_re, im: i_im, vld: i_vld});
    end

    task automatic cmp_dut(input string nm, input int d, input logic p, input logic [15:0] re,
                           input logic [15:0] im, input logic v);
        int n;
        ent_t e;
        n = hist.size();
        if (n >= d) begin
            e = hist[n - d];
            chk({nm, ".primed"}, 32'(p), 32'd1);
            chk({nm, ".o_re"}, 32'(re), 32'(e.re));
            chk({nm, ".o_im"}, 32'(im), 32'(e.im));
            chk({nm, ".o_vld"}, 32'(v), 32'(e.vld));
        end else begin
            chk({nm, ".primed"}, 32'(p), 32'd0);
            chk({nm, ".o_vld"}, 32'(v), 32'd0);
`ifdef CPLX_DLY_ZERO_FILL_EN
            chk({nm, ".o_re_zero"}, 32'(re), 32'd0);
            chk({nm, ".o_im_zero"}, 32'(im), 32'd0);
`endif
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp_dut("d1", 1, p1, re1, im1, v1);
            cmp_dut("d4", 4, p4, re4, im4, v4);
            cmp_dut("d7", 7, p7, re7, im7, v7);
            cmp_dut("d8", 8, p8, re8, im8, v8);
        end
    end

    task automatic step(input logic rn, input logic en, input logic [15:0] re,
                        input logic [15:0] im, input logic vld);
        rst_n = rn;
        w_en  = en;
        i_re  = re;
        i_im  = im;
        i_vld = vld;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        w_en  = 1'b0;
        i_re  = '0;
        i_im  = '0;
        i_vld = 1'b0;
        step(1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        checking = 1'b1;
        chk("reset.primed4", 32'(p4), 32'd0);
        chk("reset.vld4", 32'(v4), 32'd0);
        chk("reset.primed1", 32'(p1), 32'd0);

        // Priming: re=k, im=-k, vld=1.
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 16'(k), 16'(-k), 1'b1);
            if (k == 3) chk("prime.before4", 32'(p4), 32'd0);
            if (k == 4) begin
                chk("prime.at4", 32'(p4), 32'd1);
                chk("prime.re4", 32'(re4), 32'h0001);
                chk("prime.im4", 32'(im4), 32'hFFFF);
                chk("prime.vld4", 32'(v4), 32'd1);
            end
        end
        chk("prime.re4_k10", 32'(re4), 32'h0007);
        chk("prime.im4_k10", 32'(im4), 32'hFFF9);
        chk("prime.re1_k10", 32'(re1), 32'h000A);

        // Enable gaps with a counting input.
        for (int k = 11; k <= 40; k++)
            step(1'b1, (k % 3) == 2, 16'(k), 16'(~k), 1'b1);

        // Valid-tag pattern 1,0,1,1,0 then filler.
        step(1'b1, 1'b1, 16'h00A1, 16'h01A1, 1'b1);
        step(1'b1, 1'b1, 16'h00A2, 16'h01A2, 1'b0);
        step(1'b1, 1'b1, 16'h00A3, 16'h01A3, 1'b1);
        step(1'b1, 1'b1, 16'h00A4, 16'h01A4, 1'b1);
        chk("vpat.first_vld4", 32'(v4), 32'd1);
        chk("vpat.first_re4", 32'(re4), 32'h00A1);
        step(1'b1, 1'b1, 16'h00A5, 16'h01A5, 1'b0);
        chk("vpat.second_vld4", 32'(v4), 32'd0);
        chk("vpat.second_re4", 32'(re4), 32'h00A2);
        for (int k = 0; k < 6; k++)
            step(1'b1, k != 2, 16'(16'h00B0 + k), 16'(16'h01B0 + k), 1'b1);

        // Mid-run reset with w_en held high.
        step(1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
        chk("mreset.primed4", 32'(p4), 32'd0);
        chk("mreset.vld4", 32'(v4), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 16'(16'h0C00 + k), 16'(16'h0D00 + k), 1'b1);
            if (k == 3) chk("mreset.primed4_k3", 32'(p4), 32'd0);
        end
        chk("mreset.primed4_k4", 32'(p4), 32'd1);
        chk("mreset.re4_k4", 32'(re4), 32'h0C01);

        // Random samples with random enable gaps.
        for (int k = 0; k < 80; k++)
            step(1'b1, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom));

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
